// File: rtl/i2c_cfg_seq.sv
// i2c_cfg_seq: replays a fixed 7-entry (addr,data) table through a wr_req/wr_done/wr_ack write engine with power-up delay, inter-write gap, timeout and retries; status on cfg_busy/cfg_done/cfg_err/cfg_index
module i2c_cfg_seq #(
  parameter int SYS_CLK_FREQ   = 50_000_000,
  parameter int PWRUP_CYCLES   = 50_000,
  parameter int GAP_CYCLES     = 100,
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       cfg_start,
  output logic       wr_req,
  output logic [7:0] wr_reg_addr,
  output logic [7:0] wr_data,
  input  logic       wr_done,
  input  logic       wr_ack,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [2:0] cfg_index
);
  if (SYS_CLK_FREQ <= 0 || TIMEOUT_CYCLES <= 0) begin : g_bad_param
    $error("i2c_cfg_seq: SYS_CLK_FREQ and TIMEOUT_CYCLES must be positive");
  end
  localparam int PG   = PWRUP_CYCLES > GAP_CYCLES ? PWRUP_CYCLES : GAP_CYCLES;
  localparam int CMAX = PG > TIMEOUT_CYCLES ? PG : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [7:0][15:0] TBL = {16'h0000, 16'h0002, 16'h0203, 16'h0100,
                                      16'h0482, 16'h0300, 16'h1A11, 16'h1D00};
  typedef enum logic [2:0] {PWRUP, ISSUE, WAIT, GAP, DONE, ERROR} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0] idx, idx_d;
  logic [RW-1:0] retry, retry_d;
  logic [7:0] addr, addr_d, data, data_d;
  always_ff @(posedge sys_clk)
    if (rst) begin
      state <= PWRUP;
      cnt   <= '0;
      idx   <= '0;
      retry <= '0;
      addr  <= '0;
      data  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      retry <= retry_d;
      addr  <= addr_d;
      data  <= data_d;
    end
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    retry_d = retry;
    addr_d  = addr;
    data_d  = data;
    case (state)
      PWRUP:
        if (cnt == CW'(PWRUP_CYCLES)) begin
          state_d = ISSUE;
          cnt_d   = '0;
          idx_d   = '0;
          retry_d = '0;
        end else cnt_d = cnt + CW'(1);
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT:
        // wr_done is tested before the timeout so a same-cycle answer wins
        if (wr_done && wr_ack) begin
          state_d = GAP;
          cnt_d   = '0;
          idx_d   = idx + 3'd1;
          retry_d = '0;
        end else if (wr_done || cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = retry == RW'(MAX_RETRY) ? ERROR : GAP;
          retry_d = retry == RW'(MAX_RETRY) ? retry : retry + RW'(1);
          cnt_d   = '0;
        end else cnt_d = cnt + CW'(1);
      GAP:
        if (cnt == CW'(GAP_CYCLES)) begin
          state_d = idx == 3'd7 ? DONE : ISSUE;
          cnt_d   = '0;
        end else cnt_d = cnt + CW'(1);
      DONE, ERROR:
        if (cfg_start) begin
          state_d = ISSUE;
          cnt_d   = '0;
          idx_d   = '0;
          retry_d = '0;
        end
      default: state_d = PWRUP;
    endcase
    if (state_d == ISSUE) {addr_d, data_d} = TBL[idx_d];
  end
  assign wr_req      = state == ISSUE;
  assign wr_reg_addr = addr;
  assign wr_data     = data;
  assign cfg_busy    = state != DONE && state != ERROR;
  assign cfg_done    = state == DONE;
  assign cfg_err     = state == ERROR;
  assign cfg_index   = idx;
endmodule
